// File: rtl/deemph_pkg.sv
// Shared constants and types for the time-shared L/R de-emphasis scheduler.
// Coefficients are Q(BITS) fixed point; A is negative.
package deemph_pkg;

   localparam int BITS = 10;

   localparam logic signed [31:0] B_COEF = 32'sh0000_00B2;
   localparam logic signed [31:0] A_COEF = 32'shFFFF_FD66;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC0,
      MAC1,
      MAC2,
      WRITE
   } state_t;

   typedef enum logic {
      CH_L,
      CH_R
   } ch_t;

endpackage

// File: rtl/deemph_mac.sv
// Combinational signed multiply followed by round-toward-zero dequantise.
// One instance is shared by both channels of deemph_sched.
module deemph_mac #(
   parameter int DATA_WIDTH = 32,
   parameter int BITS = deemph_pkg::BITS
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam logic [PW-1:0] RND = {{(PW - BITS){1'b0}}, {BITS{1'b1}}};

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] adj;

   // Bias negatives by 2^BITS-1 so the arithmetic shift truncates toward zero.
   always_comb begin
      prod = $signed(a) * $signed(b);
      adj  = prod[PW-1] ? (prod + $signed(RND)) : prod;
      q    = DATA_WIDTH'(adj >>> BITS);
   end

endmodule

// File: rtl/deemph_sched.sv
// Round-robin L/R de-emphasis scheduler sharing one deemph_mac.
// Define DEEMPH_STATS_EN to add per-channel 16-bit commit counters.
module deemph_sched #(
   parameter int DATA_WIDTH = 32,
   parameter int BITS = deemph_pkg::BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  l_in_rd_en,
   output logic                  r_in_rd_en,
   input  logic                  l_in_empty,
   input  logic                  r_in_empty,
   input  logic [DATA_WIDTH-1:0] l_in_dout,
   input  logic [DATA_WIDTH-1:0] r_in_dout,
   output logic                  l_out_wr_en,
   output logic                  r_out_wr_en,
   input  logic                  l_out_full,
   input  logic                  r_out_full,
   output logic [DATA_WIDTH-1:0] l_out_din,
   output logic [DATA_WIDTH-1:0] r_out_din
`ifdef DEEMPH_STATS_EN
   ,
   output logic [15:0]           l_count,
   output logic [15:0]           r_count
`endif
);

   import deemph_pkg::*;

   localparam logic [DATA_WIDTH-1:0] B_W = DATA_WIDTH'(B_COEF);
   localparam logic [DATA_WIDTH-1:0] A_W = DATA_WIDTH'(A_COEF);

   state_t state_q, state_d;
   ch_t    ch_q, ch_d, grant_ch;

   logic [DATA_WIDTH-1:0] x_q, acc_q;
   logic [DATA_WIDTH-1:0] l_xp_q, l_yp_q;
   logic [DATA_WIDTH-1:0] r_xp_q, r_yp_q;
   logic [DATA_WIDTH-1:0] xp_sel, yp_sel;
   logic [DATA_WIDTH-1:0] mac_a, mac_b, mac_q;

   logic l_elig, r_elig, grant_any, commit;

   assign l_elig = !l_in_empty && !l_out_full;
   assign r_elig = !r_in_empty && !r_out_full;
   assign xp_sel = (ch_q == CH_L) ? l_xp_q : r_xp_q;
   assign yp_sel = (ch_q == CH_L) ? l_yp_q : r_yp_q;

   deemph_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .BITS      (BITS)
   ) u_mac (
      .a(mac_a),
      .b(mac_b),
      .q(mac_q)
   );

   // ch_q doubles as the last-grant record for round-robin.
   always_comb begin
      grant_any = l_elig || r_elig;
      grant_ch  = CH_L;
      unique case ({l_elig, r_elig})
         2'b11:   grant_ch = (ch_q == CH_R) ? CH_L : CH_R;
         2'b10:   grant_ch = CH_L;
         2'b01:   grant_ch = CH_R;
         default: grant_ch = CH_L;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      l_in_rd_en  = 1'b0;
      r_in_rd_en  = 1'b0;
      l_out_wr_en = 1'b0;
      r_out_wr_en = 1'b0;
      l_out_din   = '0;
      r_out_din   = '0;
      mac_a       = '0;
      mac_b       = '0;
      commit      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_any) begin
               ch_d    = grant_ch;
               state_d = LOAD;
               if (grant_ch == CH_L) l_in_rd_en = 1'b1;
               else                  r_in_rd_en = 1'b1;
            end
         end
         LOAD: state_d = MAC0;
         MAC0: begin
            mac_a   = B_W;
            mac_b   = x_q;
            state_d = MAC1;
         end
         MAC1: begin
            mac_a   = B_W;
            mac_b   = xp_sel;
            state_d = MAC2;
         end
         MAC2: begin
            mac_a   = A_W;
            mac_b   = yp_sel;
            state_d = WRITE;
         end
         WRITE: begin
            if (ch_q == CH_L) begin
               l_out_din = acc_q;
               if (!l_out_full) begin
                  l_out_wr_en = 1'b1;
                  commit      = 1'b1;
                  state_d     = IDLE;
               end
            end else begin
               r_out_din = acc_q;
               if (!r_out_full) begin
                  r_out_wr_en = 1'b1;
                  commit      = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // FIFO strobes must stay quiet while reset is held.
      if (reset) begin
         l_in_rd_en  = 1'b0;
         r_in_rd_en  = 1'b0;
         l_out_wr_en = 1'b0;
         r_out_wr_en = 1'b0;
         l_out_din   = '0;
         r_out_din   = '0;
         commit      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= CH_R;
         x_q     <= '0;
         acc_q   <= '0;
         l_xp_q  <= '0;
         l_yp_q  <= '0;
         r_xp_q  <= '0;
         r_yp_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         if (l_in_rd_en)      x_q <= l_in_dout;
         else if (r_in_rd_en) x_q <= r_in_dout;
         if (state_q == LOAD)
            acc_q <= '0;
         else if (state_q inside {MAC0, MAC1, MAC2})
            acc_q <= acc_q + mac_q;
         if (commit) begin
            if (ch_q == CH_L) begin
               l_xp_q <= x_q;
               l_yp_q <= acc_q;
            end else begin
               r_xp_q <= x_q;
               r_yp_q <= acc_q;
            end
         end
      end
   end

`ifdef DEEMPH_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         l_count <= '0;
         r_count <= '0;
      end else begin
         if (l_out_wr_en) l_count <= l_count + 16'd1;
         if (r_out_wr_en) r_count <= r_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_deemph_sched.sv
// Directed + randomized bench for deemph_sched with FIFO models and a
// per-channel recurrence reference model.
module tb_deemph_sched;

   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          l_in_rd_en, r_in_rd_en;
   logic          l_in_empty, r_in_empty;
   logic [DW-1:0] l_in_dout, r_in_dout;
   logic          l_out_wr_en, r_out_wr_en;
   logic          l_out_full, r_out_full;
   logic [DW-1:0] l_out_din, r_out_din;
`ifdef DEEMPH_STATS_EN
   logic [15:0]   l_count, r_count;
`endif

   int checks = 0;
   int errors = 0;

   int lq[$];
   int rq[$];
   int grants[$];
   int xp[2];
   int yp[2];
   int wr_cnt[2];
   bit pend;
   int pend_ch, pend_x, pend_val, rd_cyc;
   int cyc = 0;
   int last_lat, last_wr_val;
   int wr_ch_now, rd_ch_now;

   always #5 clock = ~clock;

   deemph_sched #(
      .DATA_WIDTH(DW),
      .BITS      (10)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .l_in_rd_en (l_in_rd_en),
      .r_in_rd_en (r_in_rd_en),
      .l_in_empty (l_in_empty),
      .r_in_empty (r_in_empty),
      .l_in_dout  (l_in_dout),
      .r_in_dout  (r_in_dout),
      .l_out_wr_en(l_out_wr_en),
      .r_out_wr_en(r_out_wr_en),
      .l_out_full (l_out_full),
      .r_out_full (r_out_full),
      .l_out_din  (l_out_din),
      .r_out_din  (r_out_din)
`ifdef DEEMPH_STATS_EN
      ,
      .l_count    (l_count),
      .r_count    (r_count)
`endif
   );

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Integer division truncates toward zero, which is the required rounding.
   function automatic int deq(input longint p);
      return int'(p / 64'sd1024);
   endfunction

   function automatic int model_y(input int c, input int x);
      return deq(178 * longint'(x)) + deq(178 * longint'(xp[c]))
           + deq(-666 * longint'(yp[c]));
   endfunction

   task automatic drive();
      l_in_empty = (lq.size() == 0);
      r_in_empty = (rq.size() == 0);
      l_in_dout  = (lq.size() == 0) ? '0 : DW'(lq[0]);
      r_in_dout  = (rq.size() == 0) ? '0 : DW'(rq[0]);
   endtask

   task automatic model_reset();
      pend = 1'b0;
      xp   = '{0, 0};
      yp   = '{0, 0};
   endtask

   task automatic cycle();
      int c;
      int pop_c = -1;
      @(negedge clock);
      cyc++;
      wr_ch_now = -1;
      rd_ch_now = -1;
      chk("dual_rd", l_in_rd_en & r_in_rd_en, 0);
      chk("l_rd_elig", l_in_rd_en & (l_in_empty | l_out_full), 0);
      chk("r_rd_elig", r_in_rd_en & (r_in_empty | r_out_full), 0);
      chk("l_wr_full", l_out_wr_en & l_out_full, 0);
      chk("r_wr_full", r_out_wr_en & r_out_full, 0);
      if (!pend || pend_ch != 0) chk("l_din_idle", l_out_din, 0);
      if (!pend || pend_ch != 1) chk("r_din_idle", r_out_din, 0);
      if (reset) begin
         chk("rst_strobes",
             {l_in_rd_en, r_in_rd_en, l_out_wr_en, r_out_wr_en}, 0);
      end else begin
         if (l_in_rd_en || r_in_rd_en) begin
            chk("rd_inflight", pend, 0);
            c        = l_in_rd_en ? 0 : 1;
            pend_x   = (c == 0) ? $signed(l_in_dout) : $signed(r_in_dout);
            pend_val = model_y(c, pend_x);
            pend_ch  = c;
            pend     = 1'b1;
            rd_cyc   = cyc;
            pop_c    = c;
            rd_ch_now = c;
            grants.push_back(c);
         end
         if (l_out_wr_en || r_out_wr_en) begin
            c = l_out_wr_en ? 0 : 1;
            last_wr_val = (c == 0) ? $signed(l_out_din) : $signed(r_out_din);
            chk("wr_dual", l_out_wr_en & r_out_wr_en, 0);
            chk("wr_pend", pend, 1);
            chk("wr_ch", c, pend_ch);
            chk("wr_val", last_wr_val, pend_val);
            xp[c]     = pend_x;
            yp[c]     = pend_val;
            pend      = 1'b0;
            last_lat  = cyc - rd_cyc;
            wr_cnt[c] = wr_cnt[c] + 1;
            wr_ch_now = c;
         end
      end
      @(posedge clock);
      #1;
      if (pop_c == 0) void'(lq.pop_front());
      if (pop_c == 1) void'(rq.pop_front());
      drive();
   endtask

   task automatic wait_wr(input int ch, input int budget, input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (wr_ch_now != ch && n < budget);
      chk(tag, wr_ch_now, ch);
   endtask

   task automatic wait_rd(input int ch, input int budget, input string tag);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (rd_ch_now != ch && n < budget);
      chk(tag, rd_ch_now, ch);
   endtask

   task automatic drain(input int budget, input string tag);
      int n = 0;
      while ((lq.size() != 0 || rq.size() != 0 || pend) && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, lq.size() + rq.size() + int'(pend), 0);
   endtask

   initial begin
      int base, gi;
      reset      = 1'b1;
      l_out_full = 1'b0;
      r_out_full = 1'b0;
      wr_cnt     = '{0, 0};
      model_reset();
      lq.push_back(1024);
      drive();
      repeat (3) cycle();
      chk("rst_l_rd", l_in_rd_en, 0);
      chk("rst_l_din", l_out_din, 0);
      chk("rst_r_din", r_out_din, 0);
      reset = 1'b0;

      wait_wr(0, 20, "s1_wr");
      chk("s1_val", last_wr_val, 178);
      chk("s1_lat", last_lat, 5);
      chk("s1_first_l", grants[0], 0);

      lq.push_back(1024);
      drive();
      wait_wr(0, 20, "s2_wr");
      chk("s2_val", last_wr_val, 241);

      rq.push_back(1024);
      drive();
      wait_wr(1, 20, "s3_wr");
      chk("s3_val", last_wr_val, 178);
      chk("s3_lat", last_lat, 5);

      grants.delete();
      repeat (4) begin
         lq.push_back(int'($urandom));
         rq.push_back(int'($urandom));
      end
      drive();
      drain(200, "rr_drain");
      chk("rr_n", grants.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < grants.size()) chk($sformatf("rr_%0d", i), grants[i], i % 2);

      base       = wr_cnt[0];
      l_out_full = 1'b1;
      repeat (2) lq.push_back(int'($urandom));
      repeat (3) rq.push_back(int'($urandom));
      drive();
      wait_wr(1, 20, "nf_r0");
      wait_wr(1, 20, "nf_r1");
      chk("nf_no_l", wr_cnt[0], base);
      gi         = grants.size();
      l_out_full = 1'b0;
      wait_wr(0, 20, "nf_l_wr");
      if (gi < grants.size()) chk("nf_l_next", grants[gi], 0);
      drain(200, "nf_drain");

      base = wr_cnt[0];
      lq.push_back(int'($urandom));
      drive();
      wait_rd(0, 20, "st_rd");
      l_out_full = 1'b1;
      repeat (10) cycle();
      chk("st_nowr", wr_cnt[0], base);
      chk("st_din", $signed(l_out_din), pend_val);
      l_out_full = 1'b0;
      wait_wr(0, 5, "st_wr");
      repeat (3) cycle();
      chk("st_once", wr_cnt[0], base + 1);

      lq.push_back(1024);
      drive();
      wait_rd(0, 20, "rs_rd");
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      model_reset();
      base = wr_cnt[0] + wr_cnt[1];
      repeat (10) cycle();
      chk("rs_nowr", wr_cnt[0] + wr_cnt[1], base);
      lq.push_back(1024);
      drive();
      wait_wr(0, 20, "rs_wr");
      chk("rs_val", last_wr_val, 178);
      lq.push_back(int'($urandom));
      lq.push_back(int'($urandom));
      drive();
      drain(100, "rs_drain");
`ifdef DEEMPH_STATS_EN
      chk("l_count", l_count, 3);
      chk("r_count", r_count, 0);
`endif

      repeat (400) begin
         if ($urandom_range(0, 3) == 0 && lq.size() < 4)
            lq.push_back(int'($urandom));
         if ($urandom_range(0, 3) == 0 && rq.size() < 4)
            rq.push_back(int'($urandom));
         l_out_full = ($urandom_range(0, 3) == 0);
         r_out_full = ($urandom_range(0, 3) == 0);
         drive();
         cycle();
      end
      l_out_full = 1'b0;
      r_out_full = 1'b0;
      drain(500, "rnd_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/deemph_sched.md
DEEMPH_SCHED -- requirements
Module: deemph_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width of all data ports.
REQ-002 Parameter BITS, default 10, fixed-point fraction bits.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 l_in_rd_en / r_in_rd_en  out  1  per-channel input FIFO pop (first-word-fall-through).
REQ-006 l_in_empty / r_in_empty  in  1  per-channel input FIFO empty.
REQ-007 l_in_dout / r_in_dout  in  DATA_WIDTH  per-channel input sample, signed.
REQ-008 l_out_wr_en / r_out_wr_en  out  1  per-channel output FIFO push.
REQ-009 l_out_full / r_out_full  in  1  per-channel output FIFO full.
REQ-010 l_out_din / r_out_din  out  DATA_WIDTH  per-channel de-emphasised sample, signed.

Function
REQ-011 The block shall time-share one deemph_mac between the L and R channels, keeping separate x_prev and y_prev history per channel.
REQ-012 Per sample: y[n] = DEQ(B*x[n]) + DEQ(B*x[n-1]) + DEQ(A*y[n-1]), where B = 0x000000B2 and A = 0xFFFFFD66 (-666).
REQ-013 Products shall be 2*DATA_WIDTH signed.
REQ-014 DEQ shall apply an arithmetic right shift by BITS, adding (2^BITS - 1) first when the product is negative (round toward zero), then truncate to DATA_WIDTH.
REQ-015 The three-term sum shall wrap modulo 2^DATA_WIDTH.
REQ-016 FSM states: IDLE, LOAD, MAC0, MAC1, MAC2, WRITE.
REQ-017 A channel is eligible when its in_empty=0 and its out_full=0.
REQ-018 IDLE: if any channel is eligible, grant one, assert its in_rd_en for exactly that cycle, capture in_dout, and go to LOAD; otherwise stay in IDLE.
REQ-019 Arbitration shall be round-robin: if both channels are eligible, grant the channel not granted last; if only one is eligible, grant it regardless of history.
REQ-020 LOAD -> MAC0 -> MAC1 -> MAC2 shall issue one multiply per state (B*x, B*x_prev, A*y_prev) and accumulate.
REQ-021 WRITE: if the granted out_full=0, assert that channel's out_wr_en for one cycle with the sum on out_din, set x_prev=x and y_prev=sum, and go to IDLE; otherwise hold in WRITE with wr_en low.
REQ-022 Latency shall be rd_en at cycle T to wr_en at cycle T+5 when unstalled; at most one sample in flight.
REQ-023 The non-granted channel's rd_en and wr_en shall stay 0; out_din of an idle channel shall be 0.
REQ-024 A channel's history shall change only on its own WRITE commit.

Reset
REQ-025 Reset shall force state=IDLE, all rd_en/wr_en=0, all out_din=0, all history=0, and last grant=R so that L is served first.
REQ-026 Reset mid-operation shall discard the in-flight sample with no write and no history update.

Configuration
REQ-027 With DEEMPH_STATS_EN defined: add output ports l_count and r_count, 16 bits each, which increment on each committed write of their channel, wrap at 0xFFFF->0, and reset to 0.
REQ-028 Without DEEMPH_STATS_EN: these ports and counters shall not exist; all other behaviour is identical.

Structure
REQ-029 Package deemph_pkg shall hold the B_COEF and A_COEF constants, BITS, the FSM state enum typedef, and the channel enum (CH_L, CH_R).
REQ-030 Sub-module deemph_mac shall be combinational: one signed multiply plus DEQ.
REQ-031 FSM, arbiter, accumulator and history shall reside in deemph_sched.

Verification
REQ-032 Single L sample 1024 (0x400) after reset -> l_out_din=178, 5 cycles after l_in_rd_en.
REQ-033 Second L sample 1024 -> 178 + 178 + DEQ(-118548 = -115) = 241; R history untouched (R sample 1024 then outputs 178).
REQ-034 Both FIFOs non-empty for 4 samples each -> grant order L,R,L,R,...; no double-grant.
REQ-035 l_out_full=1 throughout, both inputs non-empty -> only R served; deassert l_out_full -> L served next.
REQ-036 l_out_full asserted while in WRITE -> FSM holds, wr_en low; release -> exactly one write with the correct value.
REQ-037 Reset pulsed during MAC1 -> no wr_en, history=0, next sample 1024 -> 178; with DEEMPH_STATS_EN, 3 L commits -> l_count=3.
